// File: rtl/key_debounce.sv
// ============================================================================
// Module   : key_debounce
// Brief    : Per-key synchroniser and debouncer for active-low pushbuttons,
//            producing a clean level plus press/release/long-press pulses.
// Revision : 1.0
// ============================================================================
`default_nettype none

module key_debounce #(
    parameter int KEY_NUM      = 4,
    parameter int DEBOUNCE_CNT = 999_999,
    parameter int LONG_CNT     = 49_999_999,
    parameter int CNT_W        = 26
) (
    input  logic               sclk_i,
    input  logic               s_rst_i,
    input  logic [KEY_NUM-1:0] key_n_i,
    output logic [KEY_NUM-1:0] key_level_o,
    output logic [KEY_NUM-1:0] key_press_o,
    output logic [KEY_NUM-1:0] key_release_o,
    output logic [KEY_NUM-1:0] key_long_o
);

    typedef enum logic [1:0] {
        ST_IDLE       = 2'd0,
        ST_PRESS_DB   = 2'd1,
        ST_HELD       = 2'd2,
        ST_RELEASE_DB = 2'd3
    } state_t;

    localparam logic [CNT_W-1:0] c_DEB_MAX  = CNT_W'(DEBOUNCE_CNT);
    localparam logic [CNT_W-1:0] c_LONG_MAX = CNT_W'(LONG_CNT);
    localparam logic [CNT_W-1:0] c_ONE      = CNT_W'(1);

    // Synchroniser resets to the released level so a held key is seen as a fresh press.
    logic [KEY_NUM-1:0] sync1_q;
    logic [KEY_NUM-1:0] sync2_q;
    logic [KEY_NUM-1:0] key_s;

    always_ff @(posedge sclk_i or posedge s_rst_i) begin
        if (s_rst_i) begin
            sync1_q <= '1;
            sync2_q <= '1;
        end else begin
            sync1_q <= key_n_i;
            sync2_q <= sync1_q;
        end
    end

    assign key_s = ~sync2_q;

    for (genvar k = 0; k < KEY_NUM; k++) begin : g_key
        state_t           state_q, state_d;
        logic [CNT_W-1:0] cnt_q, cnt_d;
        logic             long_done_q, long_done_d;
        logic             level_q, level_d;
        logic             press_q, press_d;
        logic             release_q, release_d;
        logic             long_q, long_d;

        always_ff @(posedge sclk_i or posedge s_rst_i) begin
            if (s_rst_i) begin
                state_q     <= ST_IDLE;
                cnt_q       <= '0;
                long_done_q <= 1'b0;
                level_q     <= 1'b0;
                press_q     <= 1'b0;
                release_q   <= 1'b0;
                long_q      <= 1'b0;
            end else begin
                state_q     <= state_d;
                cnt_q       <= cnt_d;
                long_done_q <= long_done_d;
                level_q     <= level_d;
                press_q     <= press_d;
                release_q   <= release_d;
                long_q      <= long_d;
            end
        end

        always_comb begin
            state_d     = state_q;
            cnt_d       = cnt_q;
            long_done_d = long_done_q;
            level_d     = level_q;
            press_d     = 1'b0;
            release_d   = 1'b0;
            long_d      = 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (key_s[k]) begin
                        state_d = ST_PRESS_DB;
                        cnt_d   = '0;
                    end
                end
                ST_PRESS_DB: begin
                    if (!key_s[k]) begin
                        state_d = ST_IDLE;
                    end else if (cnt_q == c_DEB_MAX) begin
                        state_d = ST_HELD;
                        cnt_d   = '0;
                        press_d = 1'b1;
                        level_d = 1'b1;
                    end else begin
                        cnt_d = cnt_q + c_ONE;
                    end
                end
                ST_HELD: begin
                    // Counter parks at LONG_CNT so key_long fires once per press.
                    if (!key_s[k]) begin
                        state_d = ST_RELEASE_DB;
                        cnt_d   = '0;
                    end else if ((cnt_q == c_LONG_MAX) && !long_done_q) begin
                        long_d      = 1'b1;
                        long_done_d = 1'b1;
                    end else if (cnt_q != c_LONG_MAX) begin
                        cnt_d = cnt_q + c_ONE;
                    end
                end
                ST_RELEASE_DB: begin
                    if (key_s[k]) begin
                        state_d = ST_HELD;
                        cnt_d   = '0;
                    end else if (cnt_q == c_DEB_MAX) begin
                        state_d     = ST_IDLE;
                        release_d   = 1'b1;
                        level_d     = 1'b0;
                        long_done_d = 1'b0;
                    end else begin
                        cnt_d = cnt_q + c_ONE;
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end

        assign key_level_o[k]   = level_q;
        assign key_press_o[k]   = press_q;
        assign key_release_o[k] = release_q;
        assign key_long_o[k]    = long_q;
    end

endmodule

`default_nettype wire

// File: tb/tb_key_debounce.sv
// ============================================================================
// Module   : tb_key_debounce
// Brief    : Self-checking bench for key_debounce with a run-length reference model.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_key_debounce;

    localparam int D = 9;
    localparam int L = 49;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [3:0] key_n = 4'hF;
    logic [3:0] key_level, key_press, key_release, key_long;

    int errors = 0;
    int checks = 0;
    int cyc    = 0;
    int base   = 0;

    key_debounce #(
        .KEY_NUM      (4),
        .DEBOUNCE_CNT (D),
        .LONG_CNT     (L),
        .CNT_W        (26)
    ) u_dut (
        .sclk_i        (clk),
        .s_rst_i       (rst),
        .key_n_i       (key_n),
        .key_level_o   (key_level),
        .key_press_o   (key_press),
        .key_release_o (key_release),
        .key_long_o    (key_long)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Reference: a key is accepted after D+2 consecutive same-valued synchronised samples;
    // long-press needs a further L+1 held samples, counted afresh after a release bounce.
    bit         s1[4] = '{1'b1, 1'b1, 1'b1, 1'b1};
    bit         s2[4] = '{1'b1, 1'b1, 1'b1, 1'b1};
    bit         lvl[4], ldone[4], bnc[4];
    int         run1[4], run0[4];
    logic [3:0] e_level = '0, e_press = '0, e_rel = '0, e_long = '0;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int k = 0; k < 4; k++) begin
                s1[k] = 1'b1; s2[k] = 1'b1; lvl[k] = 1'b0; ldone[k] = 1'b0;
                bnc[k] = 1'b0; run1[k] = 0; run0[k] = 0;
            end
            e_level = '0; e_press = '0; e_rel = '0; e_long = '0;
        end else begin
            e_press = '0; e_rel = '0; e_long = '0;
            for (int k = 0; k < 4; k++) begin
                bit ks;
                ks    = ~s2[k];
                s2[k] = s1[k];
                s1[k] = key_n[k];
                if (ks) begin run1[k]++; run0[k] = 0; end
                else    begin run0[k]++; run1[k] = 0; end
                if (!lvl[k] && ks && run1[k] == D + 2) begin
                    e_press[k] = 1'b1; lvl[k] = 1'b1; bnc[k] = 1'b0;
                end else if (lvl[k] && !ks && run0[k] == D + 2) begin
                    e_rel[k] = 1'b1; lvl[k] = 1'b0; ldone[k] = 1'b0;
                end else if (lvl[k] && ks) begin
                    if (run1[k] == 1) bnc[k] = 1'b1;
                    if (!ldone[k] && run1[k] == (bnc[k] ? L + 2 : D + L + 3)) begin
                        e_long[k] = 1'b1; ldone[k] = 1'b1;
                    end
                end
                e_level[k] = lvl[k];
            end
        end
    end

    task automatic chk(input string nm, input logic [3:0] got, input logic [3:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s t=%0t got=%b exp=%b", nm, $time, got, exp);
        end
    endtask

    task automatic chk_int(input string nm, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s t=%0t got=%0d exp=%0d", nm, $time, got, exp);
        end
    endtask

    always @(negedge clk) begin
        chk("cmp_level",   key_level,   e_level);
        chk("cmp_press",   key_press,   e_press);
        chk("cmp_release", key_release, e_rel);
        chk("cmp_long",    key_long,    e_long);
    end

    int npress[4], nrel[4], nlong[4], nlvl[4];
    always @(posedge clk) begin
        #1;
        for (int k = 0; k < 4; k++) begin
            npress[k] += int'(key_press[k]);
            nrel[k]   += int'(key_release[k]);
            nlong[k]  += int'(key_long[k]);
            nlvl[k]   += int'(key_level[k]);
        end
    end

    // The edge sampling the most recent drive is e0; wait_e(n) lands on the negedge after e_n.
    task automatic mark();
        base = cyc;
    endtask

    task automatic wait_e(input int n);
        while (cyc < base + 1 + n) @(negedge clk);
    endtask

    task automatic finish_run();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    endtask

    initial begin
        #100000;
        errors++;
        $display("FAIL watchdog t=%0t got=timeout exp=finish", $time);
        finish_run();
    end

    initial begin
        int p0, l0, r0, a0;
        repeat (3) @(negedge clk);
        chk("rst_level", key_level, 4'b0000);
        chk("rst_press", key_press, 4'b0000);
        chk("rst_long",  key_long,  4'b0000);
        rst = 1'b0;
        repeat (3) @(negedge clk);

        // Single clean press and release on key 0
        key_n[0] = 1'b0; mark();
        wait_e(11); chk("t1_press_e11", key_press, 4'b0000);
        wait_e(12); chk("t1_press_e12", key_press, 4'b0001);
        chk("t1_level_e12", key_level, 4'b0001);
        wait_e(13); chk("t1_press_e13", key_press, 4'b0000);
        wait_e(29); key_n[0] = 1'b1; mark();
        wait_e(11); chk("t1_rel_e41", key_release, 4'b0000);
        wait_e(12); chk("t1_rel_e42", key_release, 4'b0001);
        chk("t1_level_e42", key_level, 4'b0000);
        wait_e(20);

        // Bouncy key 1
        p0 = npress[1];
        repeat (4) begin
            key_n[1] = 1'b0; repeat (5) @(negedge clk);
            key_n[1] = 1'b1; repeat (3) @(negedge clk);
        end
        chk_int("t2_bounce_press", npress[1] - p0, 0);
        key_n[1] = 1'b0; mark();
        wait_e(11); chk("t2_press_e11", key_press, 4'b0000);
        wait_e(12); chk("t2_press_e12", key_press, 4'b0010);
        wait_e(20); key_n[1] = 1'b1; mark();
        wait_e(20); chk_int("t2_press_count", npress[1] - p0, 1);

        // Long press on key 2
        l0 = nlong[2];
        key_n[2] = 1'b0; mark();
        wait_e(12); chk("t3_press_e12", key_press, 4'b0100);
        wait_e(61); chk("t3_long_e61", key_long, 4'b0000);
        wait_e(62); chk("t3_long_e62", key_long, 4'b0100);
        wait_e(99); key_n[2] = 1'b1;
        chk_int("t3_long_count", nlong[2] - l0, 1);
        mark();
        wait_e(12); chk("t3_rel", key_release, 4'b0100);
        wait_e(20);

        // Keys 0 and 3 together
        key_n = 4'b0110; mark();
        wait_e(12); chk("t4_press", key_press, 4'b1001);
        chk("t4_level", key_level, 4'b1001);
        wait_e(20); key_n = 4'hF; mark();
        wait_e(12); chk("t4_rel", key_release, 4'b1001);
        wait_e(20);

        // Reset while key 0 is held
        key_n[0] = 1'b0; mark();
        wait_e(20); chk("t5_level_held", key_level, 4'b0001);
        r0 = nrel[0];
        #2 rst = 1'b1;
        #1 chk("t5_async_level", key_level, 4'b0000);
        chk("t5_async_press", key_press | key_release | key_long, 4'b0000);
        repeat (3) @(negedge clk);
        rst = 1'b0; mark();
        wait_e(11); chk("t5_press_e11", key_press, 4'b0000);
        chk_int("t5_no_release", nrel[0] - r0, 0);
        wait_e(12); chk("t5_press_e12", key_press, 4'b0001);
        wait_e(20); key_n[0] = 1'b1; mark();
        wait_e(20);

        // Short glitch on key 3
        a0 = npress[3] + nrel[3] + nlong[3] + nlvl[3];
        key_n[3] = 1'b0; mark();
        wait_e(4); key_n[3] = 1'b1;
        wait_e(30);
        chk_int("t6_activity", npress[3] + nrel[3] + nlong[3] + nlvl[3] - a0, 0);
        chk("t6_level", key_level, 4'b0000);

        finish_run();
    end

endmodule

`default_nettype wire
